// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks pending load results per architectural register
// and drives PC/IF-ID stall, ID/EX bubble, IF/ID flush and a saturating stall counter.
module hazard_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16,
    localparam int RA_W        = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_id_valid,
    input  logic [RA_W-1:0]     io_id_rs1,
    input  logic [RA_W-1:0]     io_id_rs2,
    input  logic                io_id_rs1_used,
    input  logic                io_id_rs2_used,
    input  logic                io_id_memRead,
    input  logic [RA_W-1:0]     io_id_rd,
    input  logic                io_mem_stall,
    input  logic                io_branch_taken,
    output logic                io_pc_stall,
    output logic                io_inst_stall,
    output logic                io_ctrl_bubble,
    output logic                io_flush,
    output logic [NUM_REGS-1:0] io_busy_mask,
    output logic [CNT_W-1:0]    io_stall_count
);

    localparam int            CW       = $clog2(LOAD_LATENCY + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LATENCY);

    generate
        if (LOAD_LATENCY < 1 || LOAD_LATENCY > 7 || XLEN < 1) begin : g_paramCheck
            $error("hazard_scoreboard: LOAD_LATENCY must lie in 1..7");
        end
    endgenerate

    logic [CW-1:0]       r_cnt [NUM_REGS];
    logic [CNT_W-1:0]    r_stallCount;
    logic [NUM_REGS-1:0] w_busyMask;
    logic                w_rs1Hit;
    logic                w_rs2Hit;
    logic                w_hazard;
    logic                w_issue;
    logic                w_loadIssue;

    // x0 is hardwired to zero, so its slot never reports busy.
    always_comb begin
        w_busyMask = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_busyMask[r] = (r_cnt[r] != '0);
        end
    end

    assign w_rs1Hit    = io_id_rs1_used && (io_id_rs1 != '0) && w_busyMask[io_id_rs1];
    assign w_rs2Hit    = io_id_rs2_used && (io_id_rs2 != '0) && w_busyMask[io_id_rs2];
    assign w_hazard    = io_id_valid && (w_rs1Hit || w_rs2Hit);
    assign w_issue     = io_id_valid && !io_branch_taken && !io_mem_stall && !w_hazard;
    assign w_loadIssue = w_issue && io_id_memRead && (io_id_rd != '0);

    // A taken branch outranks a memory freeze, which outranks a load-use hazard.
    always_comb begin
        io_pc_stall    = 1'b0;
        io_inst_stall  = 1'b0;
        io_ctrl_bubble = 1'b0;
        io_flush       = 1'b0;
        if (io_branch_taken) begin
            io_flush       = 1'b1;
            io_ctrl_bubble = 1'b1;
        end else if (io_mem_stall) begin
            io_pc_stall   = 1'b1;
            io_inst_stall = 1'b1;
        end else if (w_hazard) begin
            io_pc_stall    = 1'b1;
            io_inst_stall  = 1'b1;
            io_ctrl_bubble = 1'b1;
        end
    end

    // A freshly issued load reloads its destination slot, overriding any older countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (!io_mem_stall) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_loadIssue && (io_id_rd == RA_W'(r))) begin
                    r_cnt[r] <= LOAD_CNT;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stallCount <= '0;
        end else if (!io_branch_taken && !io_mem_stall && w_hazard && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign io_busy_mask   = w_busyMask;
    assign io_stall_count = r_stallCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: four instances (latency 1, 2, 3, 7) share one directed
// stimulus stream and are checked every cycle against an age-based scoreboard model.
module tb_hazard_scoreboard;

    localparam int NI = 4;

    logic clock = 1'b0;
    logic reset;
    logic idValid;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic [4:0] idRd;
    logic rs1Used;
    logic rs2Used;
    logic memRead;
    logic memStall;
    logic branchTaken;

    logic [NI-1:0]       pcStall;
    logic [NI-1:0]       instStall;
    logic [NI-1:0]       ctrlBubble;
    logic [NI-1:0]       flush;
    logic [NI-1:0][31:0] busyMask;
    logic [15:0]         sc0;
    logic [15:0]         sc1;
    logic [15:0]         sc2;
    logic [1:0]          sc3;

    int errors = 0;
    int checks = 0;

    // Model: per instance, whether a register has a load in flight and how many
    // unfrozen clock edges have passed since that load issued.
    int latency[NI]  = '{1, 2, 3, 7};
    int countMax[NI] = '{65535, 65535, 65535, 3};
    bit tracked[NI][32];
    int age[NI][32];
    int modelStalls[NI];
    int pcCount[NI];

    always #5 clock = ~clock;

    hazard_scoreboard #(.LOAD_LATENCY(1)) dutL1 (
        .clock(clock), .reset(reset), .io_id_valid(idValid), .io_id_rs1(idRs1), .io_id_rs2(idRs2),
        .io_id_rs1_used(rs1Used), .io_id_rs2_used(rs2Used), .io_id_memRead(memRead), .io_id_rd(idRd),
        .io_mem_stall(memStall), .io_branch_taken(branchTaken), .io_pc_stall(pcStall[0]),
        .io_inst_stall(instStall[0]), .io_ctrl_bubble(ctrlBubble[0]), .io_flush(flush[0]),
        .io_busy_mask(busyMask[0]), .io_stall_count(sc0));

    hazard_scoreboard #(.LOAD_LATENCY(2)) dutL2 (
        .clock(clock), .reset(reset), .io_id_valid(idValid), .io_id_rs1(idRs1), .io_id_rs2(idRs2),
        .io_id_rs1_used(rs1Used), .io_id_rs2_used(rs2Used), .io_id_memRead(memRead), .io_id_rd(idRd),
        .io_mem_stall(memStall), .io_branch_taken(branchTaken), .io_pc_stall(pcStall[1]),
        .io_inst_stall(instStall[1]), .io_ctrl_bubble(ctrlBubble[1]), .io_flush(flush[1]),
        .io_busy_mask(busyMask[1]), .io_stall_count(sc1));

    hazard_scoreboard #(.LOAD_LATENCY(3)) dutL3 (
        .clock(clock), .reset(reset), .io_id_valid(idValid), .io_id_rs1(idRs1), .io_id_rs2(idRs2),
        .io_id_rs1_used(rs1Used), .io_id_rs2_used(rs2Used), .io_id_memRead(memRead), .io_id_rd(idRd),
        .io_mem_stall(memStall), .io_branch_taken(branchTaken), .io_pc_stall(pcStall[2]),
        .io_inst_stall(instStall[2]), .io_ctrl_bubble(ctrlBubble[2]), .io_flush(flush[2]),
        .io_busy_mask(busyMask[2]), .io_stall_count(sc2));

    hazard_scoreboard #(.LOAD_LATENCY(7), .CNT_W(2)) dutL7 (
        .clock(clock), .reset(reset), .io_id_valid(idValid), .io_id_rs1(idRs1), .io_id_rs2(idRs2),
        .io_id_rs1_used(rs1Used), .io_id_rs2_used(rs2Used), .io_id_memRead(memRead), .io_id_rd(idRd),
        .io_mem_stall(memStall), .io_branch_taken(branchTaken), .io_pc_stall(pcStall[3]),
        .io_inst_stall(instStall[3]), .io_ctrl_bubble(ctrlBubble[3]), .io_flush(flush[3]),
        .io_busy_mask(busyMask[3]), .io_stall_count(sc3));

    function automatic logic [15:0] actCount(int k);
        case (k)
            0:       return sc0;
            1:       return sc1;
            2:       return sc2;
            default: return {14'd0, sc3};
        endcase
    endfunction

    function automatic bit modelBusy(int k, int r);
        return (r != 0) && tracked[k][r] && (age[k][r] < latency[k]);
    endfunction

    function automatic bit modelHazard(int k);
        return idValid && ((rs1Used && modelBusy(k, int'(idRs1))) || (rs2Used && modelBusy(k, int'(idRs2))));
    endfunction

    task automatic checkOutput(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d (latency %0d) at %0t: got %0h expected %0h",
                     name, k, latency[k], $time, act, exp);
        end
    endtask

    // Model update on each clock edge, using the inputs that were stable before the edge.
    always @(posedge clock or posedge reset) begin : modelUpdate
        bit hz;
        bit issue;
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                modelStalls[k] <= 0;
                for (int r = 0; r < 32; r++) begin
                    tracked[k][r] <= 1'b0;
                    age[k][r]     <= 0;
                end
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                hz    = modelHazard(k);
                issue = idValid && !branchTaken && !memStall && !hz;
                if (!branchTaken && !memStall && hz && modelStalls[k] < countMax[k])
                    modelStalls[k] <= modelStalls[k] + 1;
                for (int r = 0; r < 32; r++) begin
                    if (issue && memRead && int'(idRd) == r && r != 0) begin
                        tracked[k][r] <= 1'b1;
                        age[k][r]     <= 0;
                    end else if (!memStall && tracked[k][r] && age[k][r] < 100) begin
                        age[k][r] <= age[k][r] + 1;
                    end
                end
            end
        end
    end

    // Compare every instance against the model on every falling edge.
    always @(negedge clock) begin : compare
        bit hz;
        logic [31:0] expMask;
        for (int k = 0; k < NI; k++) begin
            hz = modelHazard(k);
            expMask = '0;
            for (int r = 0; r < 32; r++) expMask[r] = modelBusy(k, r);
            checkOutput("flush", k, flush[k], branchTaken);
            checkOutput("ctrlBubble", k, ctrlBubble[k], branchTaken || (!memStall && hz));
            checkOutput("pcStall", k, pcStall[k], !branchTaken && (memStall || hz));
            checkOutput("instStall", k, instStall[k], !branchTaken && (memStall || hz));
            checkOutput("busyMask", k, busyMask[k], expMask);
            checkOutput("stallCount", k, actCount(k), modelStalls[k]);
        end
    end

    task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                                 input bit ld, input int rd, input bit ms, input bit br);
        idValid     = v;
        idRs1       = 5'(rs1);
        rs1Used     = u1;
        idRs2       = 5'(rs2);
        rs2Used     = u2;
        memRead     = ld;
        idRd        = 5'(rd);
        memStall    = ms;
        branchTaken = br;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clearCounts();
        for (int k = 0; k < NI; k++) pcCount[k] = 0;
    endtask

    task automatic samplePc();
        #2;
        for (int k = 0; k < NI; k++) pcCount[k] += int'(pcStall[k]);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        #2;
        for (int k = 0; k < NI; k++) begin
            checkOutput("resetMask", k, busyMask[k], 0);
            checkOutput("resetPc", k, pcStall[k], 0);
            checkOutput("resetCount", k, actCount(k), 0);
        end
        step();
        reset = 1'b0;

        // lw x5,0(x2) then add x6,x5,x1 held in ID
        applyStimulus(1, 2, 1, 0, 0, 1, 5, 0, 0);
        step();
        clearCounts();
        applyStimulus(1, 5, 1, 1, 1, 0, 6, 0, 0);
        #1;
        checkOutput("loadBusyX5", 0, busyMask[0], 32'h20);
        checkOutput("loadUseStall", 0, pcStall[0], 1);
        for (int c = 0; c < 8; c++) begin samplePc(); step(); end
        idle();
        checkOutput("aPc", 0, pcCount[0], 1);
        checkOutput("aPc", 1, pcCount[1], 2);
        checkOutput("aPc", 2, pcCount[2], 3);
        checkOutput("aPc", 3, pcCount[3], 7);
        checkOutput("aCount", 0, actCount(0), 1);
        checkOutput("aCount", 2, actCount(2), 3);
        checkOutput("aCountSat", 3, actCount(3), 3);
        step();

        // lw x7 then consumer of x7, memory stall in consumer cycles 1 and 2
        doReset();
        applyStimulus(1, 2, 1, 0, 0, 1, 7, 0, 0);
        step();
        clearCounts();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, 7, 1, 0, 0, 0, 10, (c == 1 || c == 2), 0);
            samplePc();
            step();
        end
        idle();
        checkOutput("bPc", 0, pcCount[0], 3);
        checkOutput("bPc", 1, pcCount[1], 4);
        checkOutput("bPc", 2, pcCount[2], 5);
        checkOutput("bPc", 3, pcCount[3], 8);
        checkOutput("bCount", 2, actCount(2), 3);
        checkOutput("bCount", 1, actCount(1), 2);
        step();

        // lw x0 then consumer of x0: never tracked
        doReset();
        applyStimulus(1, 2, 1, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 1, 0, 1, 0, 9, 0, 0);
        #2;
        for (int k = 0; k < NI; k++) begin
            checkOutput("x0Mask", k, busyMask[k], 0);
            checkOutput("x0Stall", k, pcStall[k], 0);
        end
        step();
        idle();
        step();

        // lw x3, lw x4, add x8,x3,x4
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 1, 3, 0, 0);
        step();
        applyStimulus(1, 1, 1, 0, 0, 1, 4, 0, 0);
        step();
        clearCounts();
        applyStimulus(1, 3, 1, 4, 1, 0, 8, 0, 0);
        #1;
        checkOutput("overlapMask", 1, busyMask[1], 32'h18);
        checkOutput("overlapMask", 0, busyMask[0], 32'h10);
        for (int c = 0; c < 8; c++) begin samplePc(); step(); end
        idle();
        checkOutput("dPc", 0, pcCount[0], 1);
        checkOutput("dPc", 1, pcCount[1], 2);
        checkOutput("dPc", 2, pcCount[2], 3);
        checkOutput("dPc", 3, pcCount[3], 7);
        checkOutput("dCount", 1, actCount(1), 2);
        step();

        // lw x9, consumer under taken branch, then branch with memory stall, then plain consumer
        doReset();
        applyStimulus(1, 2, 1, 0, 0, 1, 9, 0, 0);
        step();
        applyStimulus(1, 9, 1, 0, 0, 0, 11, 0, 1);
        #2;
        checkOutput("brFlush", 0, flush[0], 1);
        checkOutput("brBubble", 0, ctrlBubble[0], 1);
        checkOutput("brPc", 0, pcStall[0], 0);
        step();
        applyStimulus(1, 9, 1, 0, 0, 0, 11, 1, 1);
        #2;
        checkOutput("brMsFlush", 2, flush[2], 1);
        checkOutput("brMsPc", 2, pcStall[2], 0);
        checkOutput("brCount", 0, actCount(0), 0);
        step();
        clearCounts();
        applyStimulus(1, 9, 1, 0, 0, 0, 11, 0, 0);
        for (int c = 0; c < 4; c++) begin samplePc(); step(); end
        idle();
        checkOutput("ePc", 2, pcCount[2], 2);
        checkOutput("eCount", 2, actCount(2), 2);
        step();

        // Asynchronous reset while x5 is pending and a consumer is stalled
        applyStimulus(1, 2, 1, 0, 0, 1, 5, 0, 0);
        step();
        applyStimulus(1, 5, 1, 0, 0, 0, 6, 0, 0);
        #2;
        checkOutput("preResetMask", 0, busyMask[0], 32'h20);
        checkOutput("preResetPc", 0, pcStall[0], 1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput("asyncMask", k, busyMask[k], 0);
            checkOutput("asyncPc", k, pcStall[k], 0);
            checkOutput("asyncInst", k, instStall[k], 0);
            checkOutput("asyncBubble", k, ctrlBubble[k], 0);
            checkOutput("asyncFlush", k, flush[k], 0);
            checkOutput("asyncCount", k, actCount(k), 0);
        end
        idle();
        step();
        reset = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
